// File: rtl/mux21_arbiter_pkg.sv
// Types and helpers shared by the mux21 arbiter and its data-path mux.
`include "mux21_defs.vh"

package mux21_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = `MUX21_IDLE,
    GNT_A = `MUX21_GNT_A,
    GNT_B = `MUX21_GNT_B
  } state_e;

  // Identifies the source that most recently gave up the output.
  typedef enum logic {
    SRV_A = 1'b0,
    SRV_B = 1'b1
  } srv_e;

  // Counter width able to hold 0..max_beats.
  function automatic int cnt_width(input int max_beats);
    return $clog2(max_beats + 1);
  endfunction

endpackage

// File: rtl/mux21_defs.vh
// Shared state encodings for the mux21 arbiter, used by RTL and bench alike.
`ifndef MUX21_DEFS_VH
`define MUX21_DEFS_VH

`define MUX21_IDLE  2'd0
`define MUX21_GNT_A 2'd1
`define MUX21_GNT_B 2'd2

`endif

// File: rtl/mux21_w.sv
// Stateless width-parametrised 2:1 mux; sel=0 passes in0, sel=1 passes in1.
module mux21_w #(
  parameter int W = 9
) (
  input  logic         sel,
  input  logic [W-1:0] in0,
  input  logic [W-1:0] in1,
  output logic [W-1:0] out
);

  assign out = sel ? in1 : in0;

endmodule

// File: rtl/mux21_arbiter.sv
// Two-source packet arbiter: round-robin on ties, beat-limited grants,
// zero-latency combinational output path selected by a registered sel.
`include "mux21_defs.vh"

module mux21_arbiter
  import mux21_arbiter_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int MAX_BEATS = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_a,
  input  logic [DATA_W-1:0] data_a,
  input  logic              last_a,
  input  logic              req_b,
  input  logic [DATA_W-1:0] data_b,
  input  logic              last_b,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              gnt_a,
  output logic              gnt_b,
  output logic              sel
);

  localparam int CNT_W = cnt_width(MAX_BEATS);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MAX_BEATS - 1);

  state_e           state_q;
  logic             sel_q;
  logic [CNT_W-1:0] beat_cnt_q;
  srv_e             last_srv_q;

  logic xfer;
  logic at_limit;

  assign gnt_a     = (state_q == GNT_A);
  assign gnt_b     = (state_q == GNT_B);
  assign sel       = sel_q;
  assign out_valid = (gnt_a & req_a) | (gnt_b & req_b);
  assign xfer      = out_valid & out_ready;
  assign at_limit  = (beat_cnt_q == CNT_LIMIT);

  // Arbitration FSM with beat counter, round-robin history and mux select.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      sel_q      <= 1'b0;
      beat_cnt_q <= '0;
      last_srv_q <= SRV_B;
    end else begin
      case (state_q)
        IDLE: begin
          // A wins when alone, or on a tie when B was served last.
          if (req_a && (!req_b || last_srv_q == SRV_B)) begin
            state_q    <= GNT_A;
            sel_q      <= 1'b0;
            beat_cnt_q <= '0;
          end else if (req_b) begin
            state_q    <= GNT_B;
            sel_q      <= 1'b1;
            beat_cnt_q <= '0;
          end
        end
        GNT_A: begin
          if (!req_a) begin
            // Abort: give up the output without counting a beat.
            state_q    <= IDLE;
            last_srv_q <= SRV_A;
          end else if (xfer) begin
            if (last_a || at_limit) begin
              last_srv_q <= SRV_A;
              beat_cnt_q <= '0;
              if (req_b) begin
                state_q <= GNT_B;
                sel_q   <= 1'b1;
              end else begin
                state_q <= IDLE;
              end
            end else begin
              beat_cnt_q <= beat_cnt_q + 1'b1;
            end
          end
        end
        GNT_B: begin
          if (!req_b) begin
            state_q    <= IDLE;
            last_srv_q <= SRV_B;
          end else if (xfer) begin
            if (last_b || at_limit) begin
              last_srv_q <= SRV_B;
              beat_cnt_q <= '0;
              if (req_a) begin
                state_q <= GNT_A;
                sel_q   <= 1'b0;
              end else begin
                state_q <= IDLE;
              end
            end else begin
              beat_cnt_q <= beat_cnt_q + 1'b1;
            end
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  mux21_w #(
    .W (DATA_W + 1)
  ) u_mux (
    .sel (sel_q),
    .in0 ({last_a, data_a}),
    .in1 ({last_b, data_b}),
    .out ({out_last, out_data})
  );

endmodule

// File: tb/tb_mux21_arbiter.sv
// Directed bench for mux21_arbiter with hand-computed expectations.
`include "mux21_defs.vh"

module tb_mux21_arbiter;

  logic       clk;
  logic       rst;
  logic       req_a;
  logic [7:0] data_a;
  logic       last_a;
  logic       req_b;
  logic [7:0] data_b;
  logic       last_b;
  logic       out_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_last;
  logic       gnt_a;
  logic       gnt_b;
  logic       sel;

  int n_checks;
  int n_errors;
  int n_xfer_a;

  mux21_arbiter #(
    .DATA_W    (8),
    .MAX_BEATS (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_a     (req_a),
    .data_a    (data_a),
    .last_a    (last_a),
    .req_b     (req_b),
    .data_b    (data_b),
    .last_b    (last_b),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .gnt_a     (gnt_a),
    .gnt_b     (gnt_b),
    .sel       (sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Runaway guard: the directed sequence is far shorter than this.
  initial begin
    #20000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: actual=%0h required=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic idle_inputs();
    req_a = 1'b0; req_b = 1'b0; last_a = 1'b0; last_b = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    idle_inputs();
    data_a = 8'h3C;
    data_b = 8'h77;
    out_ready = 1'b0;
    #2;

    // Reset state: outputs idle, data path follows A.
    check("rst_gnt_a",    32'(gnt_a), 32'd0);
    check("rst_gnt_b",    32'(gnt_b), 32'd0);
    check("rst_sel",      32'(sel), 32'd0);
    check("rst_state",    32'(dut.state_q), 32'(`MUX21_IDLE));
    check("rst_beat_cnt", 32'(dut.beat_cnt_q), 32'd0);
    check("rst_out_data", 32'(out_data), 32'h3C);
    req_a = 1'b1;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    req_a = 1'b0;
    step();
    rst = 1'b0;

    // Single request: grant one cycle later, data passes straight through.
    req_a = 1'b1; data_a = 8'hA5; out_ready = 1'b1;
    check("pre_gnt_a", 32'(gnt_a), 32'd0);
    step();
    check("t1_gnt_a",     32'(gnt_a), 32'd1);
    check("t1_out_valid", 32'(out_valid), 32'd1);
    check("t1_out_data",  32'(out_data), 32'hA5);
    check("t1_sel",       32'(sel), 32'd0);
    last_a = 1'b1;
    #1;
    check("t1_out_last",  32'(out_last), 32'd1);
    step();
    check("t1_release_idle", 32'(dut.state_q), 32'(`MUX21_IDLE));
    idle_inputs();

    // Tie after reset: A first, then handover to B with no idle bubble.
    do_reset();
    req_a = 1'b1; req_b = 1'b1; data_a = 8'h11; data_b = 8'h22;
    step();
    check("t2_gnt_a",    32'(gnt_a), 32'd1);
    check("t2_data_a",   32'(out_data), 32'h11);
    last_a = 1'b1;
    step();
    check("t2_gnt_b",    32'(gnt_b), 32'd1);
    check("t2_gnt_a_off", 32'(gnt_a), 32'd0);
    check("t2_sel",      32'(sel), 32'd1);
    check("t2_data_b",   32'(out_data), 32'h22);
    req_a = 1'b0; last_a = 1'b0; last_b = 1'b1;
    step();
    check("t2_idle", 32'(dut.state_q), 32'(`MUX21_IDLE));
    idle_inputs();

    // Beat limit: A never sends last, B waiting; A gets exactly 16 beats.
    do_reset();
    req_a = 1'b1; req_b = 1'b1;
    step();
    n_xfer_a = 0;
    for (int i = 0; i < 20; i++) begin
      if (gnt_a && out_valid && out_ready) n_xfer_a++;
      step();
    end
    check("t3_xfers_a", 32'(n_xfer_a), 32'd16);
    check("t3_gnt_b",   32'(gnt_b), 32'd1);
    check("t3_cnt_b",   32'(dut.beat_cnt_q), 32'd4);
    idle_inputs();
    step();

    // Stall mid-packet: state, count and data hold; last during stall ignored.
    do_reset();
    req_a = 1'b1; data_a = 8'h5A;
    step();
    step();
    step();
    out_ready = 1'b0; last_a = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("t4_state", 32'(dut.state_q), 32'(`MUX21_GNT_A));
      check("t4_cnt",   32'(dut.beat_cnt_q), 32'd2);
      check("t4_data",  32'(out_data), 32'h5A);
    end
    out_ready = 1'b1;
    step();
    check("t4_release", 32'(gnt_a), 32'd0);
    idle_inputs();

    // Abort after 3 beats: back to IDLE, next tie goes to B.
    do_reset();
    req_a = 1'b1;
    step();
    step();
    step();
    step();
    check("t5_cnt3", 32'(dut.beat_cnt_q), 32'd3);
    req_a = 1'b0;
    step();
    check("t5_idle",     32'(dut.state_q), 32'(`MUX21_IDLE));
    check("t5_cnt_hold", 32'(dut.beat_cnt_q), 32'd3);
    req_a = 1'b1; req_b = 1'b1;
    step();
    check("t5_tie_b", 32'(gnt_b), 32'd1);
    check("t5_sel",   32'(sel), 32'd1);

    // Reset mid-packet in GNT_B: immediate drop, fresh tie grants A.
    step();
    rst = 1'b1;
    #1;
    check("t6_gnt_b",      32'(gnt_b), 32'd0);
    check("t6_sel",        32'(sel), 32'd0);
    check("t6_out_valid",  32'(out_valid), 32'd0);
    step();
    rst = 1'b0;
    step();
    check("t6_tie_a", 32'(gnt_a), 32'd1);
    idle_inputs();
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mux21_arbiter.md
MUX21_ARBITER -- requirements
Module: mux21_arbiter

Interface
REQ-001 Parameter DATA_W, default 8: data path width in bits for both sources and the output.
REQ-002 Parameter MAX_BEATS, default 16: maximum accepted beats per grant before a forced release; legal range 1..255.
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 req_a  input  1  source A requests the shared output and holds a valid beat.
REQ-006 data_a  input  DATA_W  source A beat data.
REQ-007 last_a  input  1  source A final beat of its packet.
REQ-008 req_b  input  1  source B request, same meaning as req_a.
REQ-009 data_b  input  DATA_W  source B beat data.
REQ-010 last_b  input  1  source B final beat of its packet.
REQ-011 out_ready  input  1  downstream accepts the beat this cycle.
REQ-012 out_valid  output  1  beat on out_data is valid.
REQ-013 out_data  output  DATA_W  muxed data: data_a when sel=0, data_b when sel=1.
REQ-014 out_last  output  1  muxed last flag, using the same selection as out_data.
REQ-015 gnt_a  output  1  source A owns the output; one beat is consumed when gnt_a & out_valid & out_ready.
REQ-016 gnt_b  output  1  source B owns the output.
REQ-017 sel  output  1  mux select: 0 selects A, 1 selects B.

Function
REQ-018 The FSM SHALL have exactly three states: IDLE, GNT_A and GNT_B.
REQ-019 In IDLE:
  - If only req_a is high, the next state is GNT_A.
  - If only req_b is high, the next state is GNT_B.
  - If both are high, grant goes to the source not served last (last_srv register).
  - With no request, the FSM stays in IDLE.
REQ-020 Grant latency SHALL be exactly one cycle from a request sampled in IDLE to gnt_x=1.
REQ-021 gnt_a=1 iff state is GNT_A, and gnt_b=1 iff state is GNT_B; gnt_a and gnt_b are never both 1.
REQ-022 sel SHALL be registered:
  - 0 in GNT_A, 1 in GNT_B.
  - In IDLE, sel holds its previous value.
REQ-023 The output path SHALL be combinational with zero latency:
  - out_valid = (GNT_A & req_a) | (GNT_B & req_b).
  - out_data and out_last are selected by sel.
REQ-024 A transfer SHALL be the cycle in which out_valid & out_ready = 1; no other cycle consumes a beat.
REQ-025 beat_cnt SHALL:
  - clear on entry to any grant state;
  - increment on each transfer;
  - have width ceil(log2(MAX_BEATS+1)).
REQ-026 A release occurs on a transfer when last_x=1 or when beat_cnt = MAX_BEATS-1; on release:
  - last_srv is set to the releasing source;
  - if the other source's req is high, the next state is the other grant state (no idle bubble);
  - otherwise the next state is IDLE.
REQ-027 Dropping req_x while granted without last_x (abort) SHALL:
  - return the FSM to IDLE next cycle;
  - set last_srv to x;
  - not count a beat.
REQ-028 When out_ready=0, the FSM SHALL hold its state and beat_cnt unchanged; a stall never forces a release.
REQ-029 Simultaneous last_x transfer and other-source request SHALL hand over with the new gnt in the very next cycle.
REQ-030 With MAX_BEATS=1, the grant SHALL alternate after every beat whenever both sources request.

Reset
REQ-031 While rst=1, the block SHALL hold, asynchronously:
  - state=IDLE;
  - gnt_a=0, gnt_b=0;
  - sel=0;
  - beat_cnt=0;
  - last_srv=B, so A wins the first tie.
REQ-032 During reset, out_valid SHALL be 0, and out_data/out_last SHALL follow source A.
REQ-033 Reset asserted mid-packet SHALL:
  - drop the grant immediately, with no further transfer counted;
  - require a fresh arbitration after release.
REQ-034 Reset deassertion SHALL take effect on the first rising clk edge after rst falls.

Structure
REQ-035 State encodings (IDLE=2'd0, GNT_A=2'd1, GNT_B=2'd2) SHALL live in a shared header, mux21_defs.vh, included by RTL and bench.
REQ-036 The data path SHALL be one sub-module, mux21_w: a width-parametrised (DATA_W+1) 2:1 mux carrying data and last, driven by sel.
REQ-037 All control (FSM, beat_cnt, last_srv) SHALL reside in mux21_arbiter; mux21_w SHALL contain no state.

Verification
REQ-038 Reset then req_a=1, data_a=8'hA5, out_ready=1 -> gnt_a=1 one cycle later, out_valid=1, out_data=8'hA5, sel=0.
REQ-039 Both req high from IDLE after reset -> GNT_A first; on A's last beat, gnt_b=1 next cycle with no idle cycle, sel=1.
REQ-040 A holds req for 20 beats, last_a never set, MAX_BEATS=16, B requesting -> exactly 16 transfers to A, then GNT_B.
REQ-041 out_ready=0 for 5 cycles mid-packet -> state, beat_cnt and out_data stable; no release occurs.
REQ-042 req_a dropped after 3 beats without last_a -> IDLE next cycle; a subsequent tie grants B.
REQ-043 rst pulsed while GNT_B is mid-packet -> gnt_b=0 and sel=0 immediately; after release, a tie grants A.
